// File: rtl/mips_pkg.sv
// Shared MIPS-I subset definitions: opcodes, functs, ALU operation enum.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file, two combinational read ports, one write port, $2 tap.
// Latency: reads combinational; write lands on the rising edge.
// Backpressure: none; caller gates we_i.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [32];

    // Storage update; $0 is never written so it always reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see pre-edge contents, so a same-cycle write returns the old value.
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I subset core with separate instruction/data buses and delayed branches.
// Latency: one instruction retired per enabled clock edge; memories read combinationally.
// Backpressure: clk_enable low freezes PC, registers and active; halts permanently at PC 0.
module mips_cpu_harvard
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    // pc_q is the executing instruction, npc_q the delay-slot successor.
    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic        active_q, active_d;
    logic        step;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] target26;

    logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4;

    alu_op_e     alu_op;
    logic        alu_b_imm, imm_zero_ext, shift_var;
    logic        rf_we, dst_rt, is_load, is_store;
    logic        take_branch;
    logic [31:0] branch_target;

    logic [31:0] alu_a, alu_b, alu_res, wb_data;
    logic [4:0]  sh_amt, waddr;

    assign opcode   = instr_readdata[31:26];
    assign rs       = instr_readdata[25:21];
    assign rt       = instr_readdata[20:16];
    assign rd       = instr_readdata[15:11];
    assign shamt    = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign imm16    = instr_readdata[15:0];
    assign target26 = instr_readdata[25:0];

    assign imm_sext = sext16(imm16);
    assign imm_zext = {16'h0000, imm16};
    assign pc_plus4 = pc_q + 32'd4;
    assign step     = clk_enable & active_q;

    mips_regfile u_regfile (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (rf_we & step),
        .waddr_i   (waddr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt),
        .rdata_b_o (rt_val),
        .v0_o      (register_v0)
    );

    // Decode: unknown opcodes/functs fall through the defaults and behave as NOP.
    always_comb begin
        alu_op        = ALU_ADD;
        alu_b_imm     = 1'b0;
        imm_zero_ext  = 1'b0;
        shift_var     = 1'b0;
        rf_we         = 1'b0;
        dst_rt        = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        take_branch   = 1'b0;
        branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
        unique case (opcode)
            OP_RTYPE: begin
                rf_we = 1'b1;
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    FN_JR: begin
                        rf_we         = 1'b0;
                        take_branch   = 1'b1;
                        branch_target = rs_val;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            OP_ADDIU: begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; alu_op = ALU_ADD;  end
            OP_SLTI:  begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; alu_op = ALU_SLT;  end
            OP_SLTIU: begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; alu_op = ALU_SLTU; end
            OP_ANDI:  begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_OR;  end
            OP_XORI:  begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_XOR; end
            OP_LUI:   begin rf_we = 1'b1; dst_rt = 1'b1; alu_b_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_LUI; end
            OP_LW:    begin rf_we = 1'b1; dst_rt = 1'b1; is_load = 1'b1; end
            OP_SW:    is_store = 1'b1;
            OP_BEQ:   take_branch = (rs_val == rt_val);
            OP_BNE:   take_branch = (rs_val != rt_val);
            OP_J: begin
                take_branch   = 1'b1;
                branch_target = {pc_plus4[31:28], target26, 2'b00};
            end
            default: ;
        endcase
    end

    assign alu_a  = rs_val;
    assign alu_b  = alu_b_imm ? (imm_zero_ext ? imm_zext : imm_sext) : rt_val;
    assign sh_amt = shift_var ? rs_val[4:0] : shamt;
    assign waddr  = dst_rt ? rt : rd;

    // ALU: shifts act on the rt operand (alu_b), amount from shamt or rs[4:0].
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_SLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'b0, alu_a < alu_b};
            ALU_SLL:  alu_res = alu_b << sh_amt;
            ALU_SRL:  alu_res = alu_b >> sh_amt;
            ALU_SRA:  alu_res = $signed(alu_b) >>> sh_amt;
            ALU_LUI:  alu_res = {alu_b[15:0], 16'h0000};
            default:  alu_res = '0;
        endcase
    end

    assign wb_data = is_load ? data_readdata : alu_res;

    assign data_address   = rs_val + imm_sext;
    assign data_writedata = rt_val;
    assign data_read      = is_load & active_q;
    assign data_write     = is_store & active_q;
    assign instr_address  = pc_q;
    assign active         = active_q;

    // Next-PC: delay slot always runs, redirect lands one instruction later.
    always_comb begin
        pc_d     = npc_q;
        npc_d    = take_branch ? branch_target : (npc_q + 32'd4);
        active_d = (pc_d != 32'd0);
    end

    // PC pair and run flag; frozen while disabled or halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            npc_q    <= RESET_VECTOR + 32'd4;
            active_q <= 1'b1;
        end else if (step) begin
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            active_q <= active_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Self-checking bench: ISA-level interpreter as reference, directed and random programs.
// Latency: compares bus outputs each cycle before the edge, architectural state after it.
// Backpressure: clk_enable toggled randomly in random runs.
module tb_mips_cpu_harvard;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] DMAGIC = 32'hEEEE68AC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [64];

    logic [31:0] m_regs [32];
    logic [31:0] m_pc, m_npc;
    bit          m_active;

    always #5 clk = ~clk;

    mips_cpu_harvard #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .active         (active),
        .register_v0    (register_v0),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    // Program image at RV; address 0 holds LW $2,0($0) so a halted core that kept running would show it.
    function automatic logic [31:0] fetch(input logic [31:0] a);
        logic [31:0] off;
        off = a - RV;
        if (a == 32'd0) return 32'h8C020000;
        if (off < 32'd256) return imem[off[7:2]];
        return 32'h0;
    endfunction

    assign instr_readdata = fetch(instr_address);
    assign data_readdata  = data_address ^ DMAGIC;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_imem;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc     = RV;
        m_npc    = RV + 32'd4;
        m_active = 1'b1;
    endtask

    // Architectural interpreter: expected bus activity for the current instruction, then commit.
    task automatic model_exec(input logic [31:0] ins, input bit commit,
                              output bit e_rd, output bit e_wr,
                              output logic [31:0] e_addr, output logic [31:0] e_wd);
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [31:0] s, t, simm, zimm, res, pc4, nn;
        bit          wr;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
        s = m_regs[rs]; t = m_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0, ins[15:0]};
        pc4 = m_pc + 32'd4; nn = m_npc + 32'd4;
        res = 32'h0; dst = 5'd0; wr = 1'b0;
        e_addr = s + simm; e_wd = t; e_rd = 1'b0; e_wr = 1'b0;
        if (!m_active) return;
        case (ins[31:26])
            6'h00: begin
                dst = rd; wr = 1'b1;
                case (ins[5:0])
                    6'h21: res = s + t;
                    6'h23: res = s - t;
                    6'h24: res = s & t;
                    6'h25: res = s | t;
                    6'h26: res = s ^ t;
                    6'h2A: res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
                    6'h2B: res = (s < t) ? 32'd1 : 32'd0;
                    6'h00: res = t << sh;
                    6'h02: res = t >> sh;
                    6'h03: res = $signed(t) >>> sh;
                    6'h04: res = t << s[4:0];
                    6'h06: res = t >> s[4:0];
                    6'h07: res = $signed(t) >>> s[4:0];
                    6'h08: begin wr = 1'b0; nn = s; end
                    default: wr = 1'b0;
                endcase
            end
            6'h09: begin dst = rt; wr = 1'b1; res = s + simm; end
            6'h0A: begin dst = rt; wr = 1'b1; res = ($signed(s) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h0B: begin dst = rt; wr = 1'b1; res = (s < simm) ? 32'd1 : 32'd0; end
            6'h0C: begin dst = rt; wr = 1'b1; res = s & zimm; end
            6'h0D: begin dst = rt; wr = 1'b1; res = s | zimm; end
            6'h0E: begin dst = rt; wr = 1'b1; res = s ^ zimm; end
            6'h0F: begin dst = rt; wr = 1'b1; res = {ins[15:0], 16'h0}; end
            6'h23: begin dst = rt; wr = 1'b1; e_rd = 1'b1; res = e_addr ^ DMAGIC; end
            6'h2B: e_wr = 1'b1;
            6'h04: if (s == t) nn = pc4 + (simm << 2);
            6'h05: if (s != t) nn = pc4 + (simm << 2);
            6'h02: nn = {pc4[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (commit) begin
            if (wr && dst != 5'd0) m_regs[dst] = res;
            m_pc  = m_npc;
            m_npc = nn;
            if (m_pc == 32'd0) m_active = 1'b0;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        clk_enable = 1'b1;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // mode 0: enable held high, 1: random enable, 2: enable held low.
    task automatic run_cycles(input int n, input int mode);
        logic [31:0] ea, ewd;
        bit          erd, ewr;
        for (int c = 0; c < n; c++) begin
            clk_enable = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (instr_address !== m_pc) begin
                errors++; $display("FAIL pc: got %h expected %h", instr_address, m_pc);
            end
            checks++;
            if (active !== m_active) begin
                errors++; $display("FAIL active: got %b expected %b", active, m_active);
            end
            checks++;
            if (register_v0 !== m_regs[2]) begin
                errors++; $display("FAIL v0: got %h expected %h", register_v0, m_regs[2]);
            end
            model_exec(fetch(m_pc), clk_enable, erd, ewr, ea, ewd);
            checks++;
            if (data_read !== erd || data_write !== ewr) begin
                errors++; $display("FAIL data_rw: got rd=%b wr=%b expected rd=%b wr=%b",
                                   data_read, data_write, erd, ewr);
            end
            if (erd || ewr) begin
                checks++;
                if (data_address !== ea) begin
                    errors++; $display("FAIL data_address: got %h expected %h", data_address, ea);
                end
            end
            if (ewr) begin
                checks++;
                if (data_writedata !== ewd) begin
                    errors++; $display("FAIL data_writedata: got %h expected %h", data_writedata, ewd);
                end
            end
            @(negedge clk);
        end
        clk_enable = 1'b1;
    endtask

    task automatic test_reset;
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'h0055);
        @(negedge clk);
        clk_enable = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (instr_address !== RV || active !== 1'b1 || register_v0 !== 32'h0) begin
            errors++; $display("FAIL reset_hold: got pc=%h act=%b v0=%h expected pc=%h act=1 v0=0",
                               instr_address, active, register_v0, RV);
        end
        @(negedge clk);
        clk_enable = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (instr_address !== RV || active !== 1'b1 || register_v0 !== 32'h0) begin
            errors++; $display("FAIL reset_release: got pc=%h act=%b v0=%h expected pc=%h act=1 v0=0",
                               instr_address, active, register_v0, RV);
        end
        // Reset asserted just before the edge must abort the ADDIU.
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (register_v0 !== 32'h0 || instr_address !== RV) begin
            errors++; $display("FAIL reset_abort: got v0=%h pc=%h expected v0=0 pc=%h",
                               register_v0, instr_address, RV);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_cycles(2, 0);
        checks++;
        if (register_v0 !== 32'h55) begin
            errors++; $display("FAIL first_fetch: got v0=%h expected 00000055", register_v0);
        end
    endtask

    task automatic test_lw;
        clear_imem();
        imem[0] = enc_i(6'h23, 5'd0, 5'd3, 16'h0000);
        imem[1] = enc_i(6'h09, 5'd3, 5'd2, 16'h0000);
        do_reset();
        #1;
        checks++;
        if (data_read !== 1'b1 || data_write !== 1'b0 || data_address !== 32'h0) begin
            errors++; $display("FAIL lw_bus: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0",
                               data_read, data_write, data_address);
        end
        run_cycles(2, 0);
        checks++;
        if (register_v0 !== 32'hEEEE68AC) begin
            errors++; $display("FAIL lw_value: got %h expected EEEE68AC", register_v0);
        end
    endtask

    task automatic test_sllv;
        clear_imem();
        imem[0] = enc_i(6'h0F, 5'd0, 5'd2, 16'hEEEE);
        imem[1] = enc_i(6'h0D, 5'd2, 5'd2, 16'h68AC);
        imem[2] = enc_r(5'd1, 5'd2, 5'd17, 5'd0, 6'h04);
        imem[3] = enc_i(6'h09, 5'd17, 5'd2, 16'h0000);
        do_reset();
        run_cycles(4, 0);
        checks++;
        if (register_v0 !== 32'hEEEE68AC) begin
            errors++; $display("FAIL sllv_zero: got %h expected EEEE68AC", register_v0);
        end
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'h000C);
        imem[1] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
        imem[2] = enc_i(6'h0D, 5'd3, 5'd3, 16'h5678);
        imem[3] = enc_r(5'd2, 5'd3, 5'd18, 5'd0, 6'h04);
        imem[4] = enc_i(6'h09, 5'd18, 5'd2, 16'h0000);
        do_reset();
        run_cycles(5, 0);
        checks++;
        if (register_v0 !== 32'h45678000) begin
            errors++; $display("FAIL sllv_12: got %h expected 45678000", register_v0);
        end
    endtask

    task automatic test_branch;
        clear_imem();
        imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'h0002);
        imem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'h0005);
        imem[2] = enc_i(6'h09, 5'd0, 5'd2, 16'h0063);
        imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
        do_reset();
        run_cycles(2, 0);
        checks++;
        if (register_v0 !== 32'h5 || instr_address !== RV + 32'd12) begin
            errors++; $display("FAIL beq_slot: got v0=%h pc=%h expected v0=5 pc=%h",
                               register_v0, instr_address, RV + 32'd12);
        end
        run_cycles(1, 0);
        checks++;
        if (register_v0 !== 32'h6) begin
            errors++; $display("FAIL beq_target: got %h expected 6", register_v0);
        end
    endtask

    task automatic test_jump;
        logic [31:0] tj;
        tj = (RV + 32'd32) >> 2;
        clear_imem();
        imem[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0001);
        imem[1]  = {6'h02, tj[25:0]};
        imem[2]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0002);
        imem[3]  = enc_i(6'h09, 5'd0, 5'd2, 16'h0077);
        imem[8]  = enc_i(6'h05, 5'd0, 5'd0, 16'h0005);
        imem[9]  = enc_i(6'h09, 5'd2, 5'd2, 16'h0004);
        imem[10] = enc_i(6'h09, 5'd2, 5'd2, 16'h0008);
        do_reset();
        run_cycles(6, 0);
        checks++;
        if (register_v0 !== 32'd15 || instr_address !== RV + 32'd44) begin
            errors++; $display("FAIL jump: got v0=%h pc=%h expected v0=0000000f pc=%h",
                               register_v0, instr_address, RV + 32'd44);
        end
    endtask

    task automatic test_halt;
        clear_imem();
        imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'h0003);
        imem[1] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        imem[2] = enc_i(6'h09, 5'd0, 5'd2, 16'h0007);
        imem[3] = enc_i(6'h09, 5'd0, 5'd2, 16'h0009);
        do_reset();
        run_cycles(3, 0);
        checks++;
        if (register_v0 !== 32'h7 || active !== 1'b0 || instr_address !== 32'h0) begin
            errors++; $display("FAIL halt: got v0=%h act=%b pc=%h expected v0=7 act=0 pc=0",
                               register_v0, active, instr_address);
        end
        run_cycles(5, 1);
        checks++;
        if (register_v0 !== 32'h7 || instr_address !== 32'h0 || data_read !== 1'b0) begin
            errors++; $display("FAIL halt_frozen: got v0=%h pc=%h rd=%b expected v0=7 pc=0 rd=0",
                               register_v0, instr_address, data_read);
        end
    endtask

    task automatic test_clk_enable;
        clear_imem();
        for (int i = 0; i < 8; i++) imem[i] = enc_i(6'h09, 5'd2, 5'd2, 16'h0001);
        do_reset();
        run_cycles(2, 0);
        run_cycles(4, 2);
        checks++;
        if (register_v0 !== 32'h2 || instr_address !== RV + 32'd8) begin
            errors++; $display("FAIL clk_enable_hold: got v0=%h pc=%h expected v0=2 pc=%h",
                               register_v0, instr_address, RV + 32'd8);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  fn, op;
        int          k;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        sh = 5'($urandom);
        imm = 16'($urandom);
        k = $urandom_range(0, 19);
        if (k < 8) begin
            case ($urandom_range(0, 12))
                0: fn = 6'h21;  1: fn = 6'h23;  2: fn = 6'h24;  3: fn = 6'h25;
                4: fn = 6'h26;  5: fn = 6'h2A;  6: fn = 6'h2B;  7: fn = 6'h00;
                8: fn = 6'h02;  9: fn = 6'h03;  10: fn = 6'h04; 11: fn = 6'h06;
                default: fn = 6'h07;
            endcase
            return enc_r(rs, rt, rd, sh, fn);
        end
        if (k < 15) begin
            case ($urandom_range(0, 6))
                0: op = 6'h09; 1: op = 6'h0A; 2: op = 6'h0B; 3: op = 6'h0C;
                4: op = 6'h0D; 5: op = 6'h0E; default: op = 6'h0F;
            endcase
            return enc_i(op, rs, rt, imm);
        end
        if (k == 15) return enc_i(6'h23, rs, rt, imm);
        if (k == 16) return enc_i(6'h2B, rs, rt, imm);
        if (k == 17) return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
        if (k == 18) return enc_i(6'h05, rs, rt, 16'($urandom_range(0, 3)));
        return (imm[0]) ? enc_r(rs, rt, rd, sh, 6'h3F) : enc_i(6'h3F, rs, rt, imm);
    endfunction

    task automatic test_random;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) imem[i] = rand_instr();
            do_reset();
            run_cycles(60, 1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lw();
        test_sllv();
        test_branch();
        test_jump();
        test_halt();
        test_clk_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
